// File: rtl/pipa_pulse_source.sv
// PIPA pulse source: three independent axes (X, Y, Z), each holding a signed
// pending pulse count that is drained one pulse per AGC sample strobe.
// Pulses are PULSE_W clocks wide, plus or minus by the sign of the count.
module pipa_pulse_source #(
    parameter int PULSE_W = 4,
    parameter int CNT_W   = 9
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       PIPSAM_,
    input  logic       LOAD,
    input  logic [1:0] AXIS,
    input  logic [7:0] DELTA,
    output logic       LOAD_ACK,
    output logic       PIPAXp,
    output logic       PIPAXm,
    output logic       PIPAYp,
    output logic       PIPAYm,
    output logic       PIPAZp,
    output logic       PIPAZm,
    output logic       BUSY,
    output logic       SATF,
    output logic       OVRN
);
    // Wide enough that pending +/-1 + DELTA never wraps before clipping.
    localparam int SW = CNT_W + 10;
    localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (CNT_W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} state_t;

    logic sync1_reg, sync2_reg, prev_reg, smp_reg;
    logic valid1_reg, valid2_reg;
    logic ack_reg, busy_reg, satf_reg, ovrn_reg;

    logic [2:0] pulse_p, pulse_m, clip_evt, ovr_evt, active;

    logic signed [7:0]    delta_s;
    logic signed [SW-1:0] delta_ext;
    assign delta_s   = DELTA;
    assign delta_ext = SW'(delta_s);

    // Strobe synchroniser and falling-edge detector. prev_reg only records a
    // high once the synchroniser holds a genuinely sampled value, so a strobe
    // already low at reset release cannot produce a spurious SMP.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            sync1_reg  <= 1'b1;
            sync2_reg  <= 1'b1;
            valid1_reg <= 1'b0;
            valid2_reg <= 1'b0;
            prev_reg   <= 1'b0;
            smp_reg    <= 1'b0;
        end else begin
            sync1_reg  <= PIPSAM_;
            sync2_reg  <= sync1_reg;
            valid1_reg <= 1'b1;
            valid2_reg <= valid1_reg;
            prev_reg   <= sync2_reg & valid2_reg;
            smp_reg    <= prev_reg & ~sync2_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_axis
            state_t                state_reg, state_next;
            logic [3:0]            wcnt_reg, wcnt_next;
            logic                  dir_reg, dir_next;
            logic signed [CNT_W-1:0] pend_reg, pend_next;
            logic signed [SW-1:0]  step, sum;
            logic                  hit, clip;

            assign hit = LOAD && (AXIS == 2'(gi));

            // Next-state: start a pulse on SMP from IDLE, time its width, and
            // fold the pulse step and any LOAD into one saturating update.
            always_comb begin
                state_next = state_reg;
                wcnt_next  = wcnt_reg;
                dir_next   = dir_reg;
                step       = '0;
                clip       = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (smp_reg && (pend_reg != '0)) begin
                            state_next = PULSE;
                            wcnt_next  = 4'(PULSE_W - 1);
                            dir_next   = pend_reg[CNT_W-1];
                            step       = pend_reg[CNT_W-1] ? SW'(1) : '1;
                        end
                    end
                    PULSE: begin
                        if (wcnt_reg == 4'd0) begin
                            state_next = IDLE;
                        end else begin
                            wcnt_next = wcnt_reg - 4'd1;
                        end
                    end
                    default: state_next = IDLE;
                endcase
                sum = SW'(pend_reg) + step + (hit ? delta_ext : '0);
                if (sum > MAXV) begin
                    pend_next = CNT_W'(MAXV);
                    clip      = 1'b1;
                end else if (sum < MINV) begin
                    pend_next = CNT_W'(MINV);
                    clip      = 1'b1;
                end else begin
                    pend_next = CNT_W'(sum);
                end
            end

            // Axis state register; reset kills any pulse in flight at once.
            always_ff @(posedge CLOCK or posedge rst) begin
                if (rst) begin
                    state_reg <= IDLE;
                    wcnt_reg  <= 4'd0;
                    dir_reg   <= 1'b0;
                    pend_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    wcnt_reg  <= wcnt_next;
                    dir_reg   <= dir_next;
                    pend_reg  <= pend_next;
                end
            end

            assign pulse_p[gi]  = (state_reg == PULSE) && !dir_reg;
            assign pulse_m[gi]  = (state_reg == PULSE) && dir_reg;
            assign clip_evt[gi] = clip;
            assign ovr_evt[gi]  = smp_reg && (state_reg == PULSE);
            assign active[gi]   = (pend_reg != '0) || (state_reg == PULSE);
        end
    endgenerate

    // Acknowledge, busy summary and the two sticky fault flags.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            ack_reg  <= 1'b0;
            busy_reg <= 1'b0;
            satf_reg <= 1'b0;
            ovrn_reg <= 1'b0;
        end else begin
            ack_reg  <= LOAD && (AXIS != 2'd3);
            busy_reg <= |active;
            satf_reg <= satf_reg | (LOAD && (AXIS == 2'd3)) | (|clip_evt);
            ovrn_reg <= ovrn_reg | (|ovr_evt);
        end
    end

    assign LOAD_ACK = ack_reg;
    assign BUSY     = busy_reg;
    assign SATF     = satf_reg;
    assign OVRN     = ovrn_reg;
    assign PIPAXp   = pulse_p[0];
    assign PIPAXm   = pulse_m[0];
    assign PIPAYp   = pulse_p[1];
    assign PIPAYm   = pulse_m[1];
    assign PIPAZp   = pulse_p[2];
    assign PIPAZm   = pulse_m[2];
endmodule

// File: tb/tb_pipa_pulse_source.sv
// Scoreboard bench for pipa_pulse_source: stimulus updates a per-axis
// pending-count model and queues expected pulses/acks/flag snapshots; a
// negedge monitor measures the DUT outputs and compares.
module tb_pipa_pulse_source;
    localparam int PULSE_W = 4;
    localparam int CNT_W   = 9;
    localparam int MAXP    = (1 << (CNT_W - 1)) - 1;
    localparam int MINP    = -(1 << (CNT_W - 1));

    logic       CLOCK, rst, PIPSAM_, LOAD;
    logic [1:0] AXIS;
    logic [7:0] DELTA;
    logic       LOAD_ACK, PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm;
    logic       BUSY, SATF, OVRN;

    pipa_pulse_source #(.PULSE_W(PULSE_W), .CNT_W(CNT_W)) dut (
        .CLOCK(CLOCK), .rst(rst), .PIPSAM_(PIPSAM_), .LOAD(LOAD), .AXIS(AXIS),
        .DELTA(DELTA), .LOAD_ACK(LOAD_ACK), .PIPAXp(PIPAXp), .PIPAXm(PIPAXm),
        .PIPAYp(PIPAYp), .PIPAYm(PIPAYm), .PIPAZp(PIPAZp), .PIPAZm(PIPAZm),
        .BUSY(BUSY), .SATF(SATF), .OVRN(OVRN)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        int   tag;
        logic busy;
        logic satf;
        logic ovrn;
        logic quiet;
    } snap_t;

    int    pulse_q[$];   // (axis*2+dir)*16 + width, in axis order
    int    ack_q[$];     // negedge index at which LOAD_ACK is expected
    snap_t snap_q[$];
    int    pend[3];
    bit    m_satf, m_ovrn;
    int    neg_cnt = 0;
    bit    finish_req = 0;
    int    n_pass = 0, n_total = 0;
    int    run[6];
    int    snap_tag = 0;

    // Monitor: pulse widths, p/m exclusion, acks, flag snapshots, summary.
    always @(negedge CLOCK) begin
        logic [5:0] outs;
        int exp_v, act_v;
        bit exp_ack;
        snap_t s;
        outs = {PIPAZm, PIPAZp, PIPAYm, PIPAYp, PIPAXm, PIPAXp};
        neg_cnt++;
        if (rst) begin
            for (int k = 0; k < 6; k++) run[k] = 0;
            pulse_q.delete();
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (outs[k]) begin
                    run[k]++;
                end else if (run[k] > 0) begin
                    exp_v = (pulse_q.size() > 0) ? pulse_q.pop_front() : -1;
                    act_v = k * 16 + run[k];
                    n_total++;
                    if (act_v == exp_v) n_pass++;
                    else $display("FAIL pulse: got code %0d (out %0d width %0d), expected code %0d",
                                  act_v, k, run[k], exp_v);
                    run[k] = 0;
                end
            end
            for (int a = 0; a < 3; a++) begin
                if (outs[2*a] || outs[2*a+1]) begin
                    n_total++;
                    if (!(outs[2*a] && outs[2*a+1])) n_pass++;
                    else $display("FAIL pm_exclusive axis %0d: both p and m high", a);
                end
            end
            exp_ack = (ack_q.size() > 0) && (ack_q[0] == neg_cnt);
            if (exp_ack) void'(ack_q.pop_front());
            if (exp_ack || LOAD_ACK) begin
                n_total++;
                if (LOAD_ACK == exp_ack) n_pass++;
                else $display("FAIL load_ack at negedge %0d: got %0b, expected %0b",
                              neg_cnt, LOAD_ACK, exp_ack);
            end
        end
        if (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            n_total++;
            if ({BUSY, SATF, OVRN} == {s.busy, s.satf, s.ovrn}) n_pass++;
            else $display("FAIL flags snap %0d: got busy/satf/ovrn %b, expected %b",
                          s.tag, {BUSY, SATF, OVRN}, {s.busy, s.satf, s.ovrn});
            if (s.quiet) begin
                n_total++;
                if (outs == 6'b0 && !LOAD_ACK) n_pass++;
                else $display("FAIL quiet snap %0d: got pulses %b ack %b, expected all 0",
                              s.tag, outs, LOAD_ACK);
            end
        end
        if (finish_req) begin
            n_total++;
            if (pulse_q.size() == 0 && ack_q.size() == 0) n_pass++;
            else $display("FAIL leftover: got %0d pulses and %0d acks still pending, expected 0",
                          pulse_q.size(), ack_q.size());
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end
    end

    function automatic int clamp(input int v);
        if (v > MAXP) begin m_satf = 1'b1; return MAXP; end
        if (v < MINP) begin m_satf = 1'b1; return MINP; end
        return v;
    endfunction

    // Model of one sample strobe: every axis with a nonzero count emits one
    // pulse toward zero.
    function automatic void apply_smp();
        for (int a = 0; a < 3; a++) begin
            if (pend[a] > 0) begin
                pulse_q.push_back((a * 2) * 16 + PULSE_W);
                pend[a]--;
            end else if (pend[a] < 0) begin
                pulse_q.push_back((a * 2 + 1) * 16 + PULSE_W);
                pend[a]++;
            end
        end
    endfunction

    task automatic do_load(input int a, input int d);
        @(posedge CLOCK); #1;
        LOAD = 1'b1; AXIS = a[1:0]; DELTA = d[7:0];
        if (a < 3) begin
            ack_q.push_back(neg_cnt + 2);
            pend[a] = clamp(pend[a] + d);
        end else begin
            m_satf = 1'b1;
        end
        @(posedge CLOCK); #1;
        LOAD = 1'b0;
    endtask

    task automatic do_strobe();
        @(posedge CLOCK); #1;
        PIPSAM_ = 1'b0;
        apply_smp();
        repeat (2) @(posedge CLOCK);
        #1 PIPSAM_ = 1'b1;
        repeat (10) @(posedge CLOCK);
    endtask

    // LOAD lands in the same cycle the internal strobe reaches the axes.
    task automatic strobe_load(input int a, input int d);
        @(posedge CLOCK); #1;
        PIPSAM_ = 1'b0;
        apply_smp();
        pend[a] = clamp(pend[a] + d);
        repeat (2) @(posedge CLOCK);
        #1 PIPSAM_ = 1'b1;
        @(posedge CLOCK); #1;
        LOAD = 1'b1; AXIS = a[1:0]; DELTA = d[7:0];
        ack_q.push_back(neg_cnt + 2);
        @(posedge CLOCK); #1;
        LOAD = 1'b0;
        repeat (10) @(posedge CLOCK);
    endtask

    task automatic snap(input bit quiet);
        snap_t s;
        repeat (2) @(posedge CLOCK);
        #1;
        s.tag   = snap_tag++;
        s.busy  = (pend[0] != 0) || (pend[1] != 0) || (pend[2] != 0);
        s.satf  = m_satf;
        s.ovrn  = m_ovrn;
        s.quiet = quiet;
        snap_q.push_back(s);
    endtask

    task automatic do_reset();
        @(posedge CLOCK); #1;
        rst = 1'b1;
        for (int a = 0; a < 3; a++) pend[a] = 0;
        m_satf = 1'b0; m_ovrn = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input int limit);
        int guard;
        guard = 0;
        while ((pend[0] != 0 || pend[1] != 0 || pend[2] != 0) && guard < limit) begin
            do_strobe();
            guard++;
        end
    endtask

    initial begin
        snap_t s;
        rst = 1'b1; PIPSAM_ = 1'b1; LOAD = 1'b0; AXIS = 2'd0; DELTA = 8'd0;
        for (int a = 0; a < 3; a++) pend[a] = 0;
        m_satf = 1'b0; m_ovrn = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        s.tag = snap_tag++; s.busy = 0; s.satf = 0; s.ovrn = 0; s.quiet = 1;
        snap_q.push_back(s);
        repeat (2) @(posedge CLOCK);
        #1 rst = 1'b0;
        repeat (4) @(posedge CLOCK);
        snap(1'b1);

        // Three plus pulses on X from +3, none on the fourth strobe.
        do_load(0, 3);
        for (int i = 0; i < 4; i++) begin
            do_strobe();
            snap(1'b0);
        end

        // Z minus and Y plus start on the same strobe.
        do_load(2, -2);
        do_load(1, 1);
        do_strobe();
        snap(1'b0);
        do_strobe();
        do_strobe();
        snap(1'b0);

        // LOAD coincident with SMP: direction from the old count.
        strobe_load(0, 1);
        do_strobe();
        do_load(0, 2);
        strobe_load(0, -5);
        snap(1'b0);
        drain(20);
        snap(1'b0);

        // Second strobe while X is still pulsing is ignored and flags OVRN.
        do_load(0, 2);
        @(posedge CLOCK); #1 PIPSAM_ = 1'b0;
        apply_smp();
        m_ovrn = 1'b1;
        @(posedge CLOCK); #1 PIPSAM_ = 1'b1;
        @(posedge CLOCK); #1 PIPSAM_ = 1'b0;
        @(posedge CLOCK); #1 PIPSAM_ = 1'b1;
        repeat (10) @(posedge CLOCK);
        snap(1'b0);
        drain(5);
        do_strobe();
        snap(1'b0);

        // Reset on the second cycle of a Y minus pulse.
        do_load(1, -1);
        @(posedge CLOCK); #1 PIPSAM_ = 1'b0;
        apply_smp();
        repeat (2) @(posedge CLOCK);
        #1 PIPSAM_ = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1 rst = 1'b1;
        for (int a = 0; a < 3; a++) pend[a] = 0;
        m_satf = 1'b0; m_ovrn = 1'b0;
        s.tag = snap_tag++; s.busy = 0; s.satf = 0; s.ovrn = 0; s.quiet = 1;
        snap_q.push_back(s);
        repeat (3) @(posedge CLOCK);
        #1 rst = 1'b0;
        do_strobe();
        do_strobe();
        snap(1'b1);

        // Strobe already low at reset release must not be taken as an edge.
        @(posedge CLOCK); #1 rst = 1'b1; PIPSAM_ = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1 rst = 1'b0;
        do_load(0, 1);
        repeat (8) @(posedge CLOCK);
        #1 PIPSAM_ = 1'b1;
        repeat (10) @(posedge CLOCK);
        snap(1'b0);
        do_strobe();
        snap(1'b0);

        // Positive saturation on Y, then drain all 255 pulses.
        do_load(1, 127);
        do_load(1, 127);
        do_load(1, 1);
        snap(1'b0);
        do_load(1, 10);
        snap(1'b0);
        drain(300);
        snap(1'b0);

        // Negative saturation on X, then illegal axis after a reset.
        do_reset();
        do_load(0, -128);
        do_load(0, -128);
        snap(1'b0);
        do_load(0, -1);
        snap(1'b0);
        do_reset();
        do_load(3, 5);
        snap(1'b0);
        do_strobe();

        // Randomized loads and strobes, drained at the end.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) do_strobe();
            else do_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 16)) - 8);
        end
        drain(400);
        snap(1'b0);

        repeat (5) @(posedge CLOCK);
        finish_req = 1'b1;
        repeat (10) @(posedge CLOCK);
        $display("FAIL watchdog: monitor did not finish, got no summary, expected one");
        $fatal(1, "monitor did not finish");
    end
endmodule

// File: doc/pipa_pulse_source.md
PIPA_PULSE_SOURCE -- requirements
Module: pipa_pulse_source

Interface
REQ-001 Parameter PULSE_W, default 4: width of each emitted PIPA pulse, in CLOCK cycles (legal range 1..15).
REQ-002 Parameter CNT_W, default 9: width of each axis's signed pending-pulse register.
REQ-003 CLOCK  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 PIPSAM_  input  1  active-low sample strobe from the AGC; any level, asynchronous to pulse timing.
REQ-006 LOAD  input  1  single-cycle request to add DELTA to the pending count of axis AXIS.
REQ-007 AXIS  input  2  axis select: 0=X, 1=Y, 2=Z, 3=illegal.
REQ-008 DELTA  input  8  signed two's-complement pulse count to add.
REQ-009 LOAD_ACK  output  1  one-cycle acknowledge of an accepted LOAD.
REQ-010 PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm  output  1 each  active-high plus/minus pulses toward the AGC.
REQ-011 BUSY  output  1  high while any pending count is nonzero or any pulse is active.
REQ-012 SATF  output  1  sticky flag: a saturation or illegal-axis event occurred.
REQ-013 OVRN  output  1  sticky flag: a sample strobe arrived while that axis was still pulsing.

Function
REQ-014 The block SHALL register PIPSAM_ through a 2-flop synchroniser and detect the high-to-low transition, producing the internal strobe SMP one cycle after the second flop falls.
REQ-015 Each axis SHALL run a two-state FSM: IDLE and PULSE, with a 4-bit width counter.
REQ-016 IDLE, SMP, pending>0: go to PULSE, drive the axis p output, decrement pending by 1.
REQ-017 IDLE, SMP, pending<0: go to PULSE, drive the axis m output, increment pending by 1.
REQ-018 IDLE, SMP, pending=0: stay IDLE; no output.
REQ-019 The p or m output SHALL be high for exactly PULSE_W cycles, starting the cycle after SMP; the FSM then returns to IDLE.
REQ-020 p and m of one axis SHALL never be high in the same cycle.
REQ-021 SMP while an axis is in PULSE SHALL be ignored for that axis, SHALL leave pending unchanged, and SHALL set OVRN.
REQ-022 LOAD with AXIS 0..2 SHALL add sign-extended DELTA to that axis's pending count.
REQ-023 LOAD with AXIS 0..2 SHALL assert LOAD_ACK on the next cycle.
REQ-024 LOAD with AXIS=3 SHALL alter no pending count, SHALL set SATF, and SHALL give no LOAD_ACK.
REQ-025 The pending sum SHALL saturate at +(2^(CNT_W-1)-1) and -(2^(CNT_W-1)); clipping SHALL set SATF.
REQ-026 When LOAD and SMP hit the same axis in the same cycle, the pulse direction SHALL be chosen from the old pending value.
REQ-027 In that case the new pending value SHALL be sat(old ±1 + DELTA).
REQ-028 One SMP SHALL start all eligible axes in the same cycle.
REQ-029 BUSY SHALL be the registered OR of (pending≠0 or FSM=PULSE) over the three axes.
REQ-030 SATF and OVRN SHALL clear only on rst.

Reset
REQ-031 While rst is high, all pending counts SHALL be 0 and all FSMs SHALL be IDLE.
REQ-032 While rst is high, all six pulse outputs, LOAD_ACK, BUSY, SATF and OVRN SHALL be 0, and the synchroniser flops SHALL be 1.
REQ-033 rst asserted mid-pulse SHALL drop the pulse output immediately (asynchronously), with no remnant pulse after release.
REQ-034 The first SMP after rst release SHALL be honoured only if the synchronised PIPSAM_ was seen high for at least one cycle after release.

Verification
REQ-035 LOAD AXIS=0 DELTA=+3, then 4 PIPSAM_ falls spaced 10 cycles apart -> three PIPAXp pulses, each 4 cycles wide; no pulse on the 4th strobe; BUSY falls after the 3rd pulse; LOAD_ACK=1 for one cycle.
REQ-036 LOAD AXIS=2 DELTA=-2 and LOAD AXIS=1 DELTA=+1 (separate cycles), then one strobe -> PIPAZm and PIPAYp assert in the same cycle; pending Z=-1, Y=0.
REQ-037 Y pending=+255 (CNT_W=9), then LOAD AXIS=1 DELTA=+10 -> pending Y=255, SATF=1, LOAD_ACK=1.
REQ-038 X pending=+2, strobes 2 cycles apart -> one PIPAXp pulse, OVRN=1, pending X=1.
REQ-039 X pending=0; LOAD AXIS=0 DELTA=+1 in the same cycle as SMP -> no pulse; pending X=1; the next strobe produces a PIPAXp pulse.
REQ-040 rst asserted on cycle 2 of a PIPAYm pulse -> PIPAYm=0 immediately; all flags 0; with no further LOAD, strobes after release produce no pulses.
